// File: rtl/ws_feeder_pkg.sv
// rtl/ws_feeder_pkg.sv - shared state encoding and sizing helper for the activation skew feeder
package ws_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } feeder_state_e;

  function automatic int drain_cnt_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - DEPTH-stage {vld, data} shift register, data zeroed on bubbles
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             vld_out,
  output logic [WIDTH-1:0] data_out
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  always_comb begin
    vld_d[0]  = vld_in;
    // The array multiplies every cycle, so a bubble must carry zero, not stale data.
    data_d[0] = vld_in ? data_in : '0;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign vld_out  = vld_q[DEPTH-1];
  assign data_out = data_q[DEPTH-1];

endmodule

// File: rtl/ws_act_skew_feeder.sv
// rtl/ws_act_skew_feeder.sv - diagonal-skew activation feeder with tile drain and done pulse
module ws_act_skew_feeder #(
  parameter int ROWS  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [ROWS*WIDTH-1:0] in_data,
  output logic [ROWS*WIDTH-1:0] a_out,
  output logic [ROWS-1:0]       a_vld,
  output logic                  busy,
  output logic                  done
);
  import ws_feeder_pkg::*;

  localparam int CW = drain_cnt_w(ROWS);

  feeder_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          accept;

  assign in_ready = (state_q != FLUSH);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, STREAM: begin
        if (accept) begin
          if (in_last) begin
            // A single-row array has no skew tail: the last beat is already on row 0.
            if (ROWS == 1) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = FLUSH;
              cnt_d   = CW'(ROWS - 1);
            end
          end else begin
            state_d = STREAM;
          end
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    skew_delay_line #(
      .DEPTH(r + 1),
      .WIDTH(WIDTH)
    ) u_line (
      .clk     (clk),
      .rst     (rst),
      .vld_in  (accept),
      .data_in (in_data[r*WIDTH +: WIDTH]),
      .vld_out (a_vld[r]),
      .data_out(a_out[r*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_ws_act_skew_feeder.sv
// tb/tb_ws_act_skew_feeder.sv - scoreboard bench for the activation skew feeder (ROWS=4 and ROWS=1 builds)
module tb_ws_act_skew_feeder;

  localparam int ROWS = 4;
  localparam int W    = 8;

  typedef logic [ROWS*W:0] beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_last, in_ready, busy, done;
  logic [ROWS*W-1:0] in_data, a_out;
  logic [ROWS-1:0] a_vld;

  logic            in_valid1, in_last1, in_ready1, busy1, done1;
  logic [W-1:0]    in_data1, a_out1;
  logic [0:0]      a_vld1;

  int tests = 0;
  int fails = 0;

  beat_t hist[$];
  beat_t e;

  always #5 clk = ~clk;

  ws_act_skew_feeder #(.ROWS(ROWS), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_data(in_data), .a_out(a_out), .a_vld(a_vld), .busy(busy), .done(done)
  );

  ws_act_skew_feeder #(.ROWS(1), .WIDTH(W)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_last(in_last1),
    .in_data(in_data1), .a_out(a_out1), .a_vld(a_vld1), .busy(busy1), .done(done1)
  );

  // Scoreboard: every edge pushes what the bench drove (bubble = zero); row r
  // must show the entry pushed r edges earlier.
  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
    end else begin
      hist.push_back({in_valid, in_valid ? in_data : {ROWS*W{1'b0}}});
      if (hist.size() > ROWS) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int r = 0; r < ROWS; r++) begin
        e = (hist.size() > r) ? hist[hist.size()-1-r] : '0;
        tests++;
        if ({a_vld[r], a_out[r*W +: W]} !== {e[ROWS*W], e[r*W +: W]}) begin
          fails++;
          $display("FAIL row%0d_data t=%0t got vld=%b data=%h expected vld=%b data=%h",
                   r, $time, a_vld[r], a_out[r*W +: W], e[ROWS*W], e[r*W +: W]);
        end
      end
    end
  end

  task automatic set_in(input logic v, input logic l, input logic [ROWS*W-1:0] d);
    in_valid = v;
    in_last  = l;
    in_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 0, '0);
    in_valid1 = 0; in_last1 = 0; in_data1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests++;
      if ({a_out, a_vld, in_ready, busy, done} !== {32'h0, 4'b0, 1'b1, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d got out=%h vld=%b rdy=%b busy=%b done=%b expected 0/0/1/0/0",
                 k, a_out, a_vld, in_ready, busy, done);
      end
    end
    tests++;
    if ({a_out1, a_vld1, in_ready1, busy1, done1} !== {8'h0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_idle_rows1 got out=%h vld=%b rdy=%b busy=%b done=%b", a_out1, a_vld1, in_ready1, busy1, done1);
    end
  endtask

  // Drain checks after the last accept at edge T; k counts cycles after edge T+k.
  task automatic check_drain(input string name, input int k);
    tests++;
    if ({done, in_ready, busy} !== {(k == 3), (k >= 3), (k < 3)}) begin
      fails++;
      $display("FAIL %s_drain k=%0d got done=%b rdy=%b busy=%b expected done=%b rdy=%b busy=%b",
               name, k, done, in_ready, busy, (k == 3), (k >= 3), (k < 3));
    end
  endtask

  task automatic test_single();
    logic [3:0] ev;
    @(negedge clk);
    set_in(1, 1, {8'd4, 8'hFD, 8'd2, 8'hFF});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set_in(0, 0, '0);
      check_drain("single", k);
      ev = (k < 4) ? (4'b0001 << k) : 4'b0000;
      tests++;
      if (a_vld !== ev) begin
        fails++;
        $display("FAIL single_vld k=%0d got %b expected %b", k, a_vld, ev);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ev;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_in(1, (i == 2), $urandom);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set_in(0, 0, '0);
      check_drain("b2b", k);
      for (int r = 0; r < ROWS; r++) ev[r] = ((r - k) >= 0) && ((r - k) <= 2);
      tests++;
      if (a_vld !== ev) begin
        fails++;
        $display("FAIL b2b_vld k=%0d got %b expected %b", k, a_vld, ev);
      end
    end
  endtask

  task automatic test_gapped();
    @(negedge clk);
    set_in(1, 0, {8'h81, 8'h7F, 8'hC0, 8'h11});
    @(negedge clk);
    set_in(0, 0, '0);
    tests++;
    if ({in_ready, busy} !== 2'b11) begin
      fails++;
      $display("FAIL gapped_stream got rdy=%b busy=%b expected 1/1", in_ready, busy);
    end
    @(negedge clk);
    set_in(1, 1, {8'h22, 8'h80, 8'h01, 8'hFE});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set_in(0, 0, '0);
      check_drain("gapped", k);
    end
  endtask

  task automatic test_next_tile();
    @(negedge clk);
    set_in(1, 1, {8'h10, 8'h20, 8'h30, 8'h40});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_in(0, 0, '0);
      check_drain("tileA", k);
    end
    set_in(1, 1, {8'hA1, 8'hB2, 8'hC3, 8'hD4});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set_in(0, 0, '0);
      check_drain("tileB", k);
    end
  endtask

  task automatic test_reset_flush();
    @(negedge clk);
    set_in(1, 1, {8'h55, 8'h66, 8'h77, 8'h88});
    @(negedge clk);
    set_in(0, 0, '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({a_out, a_vld, in_ready, busy, done} !== {32'h0, 4'b0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_flush got out=%h vld=%b rdy=%b busy=%b done=%b expected 0/0/1/0/0",
               a_out, a_vld, in_ready, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++;
      if ({done, in_ready, busy} !== 3'b010) begin
        fails++;
        $display("FAIL reset_flush_after k=%0d got done=%b rdy=%b busy=%b expected 0/1/0", k, done, in_ready, busy);
      end
    end
  endtask

  task automatic test_rows1();
    @(negedge clk);
    in_valid1 = 1; in_last1 = 1; in_data1 = 8'h80;
    @(negedge clk);
    in_valid1 = 0; in_last1 = 0; in_data1 = '0;
    tests++;
    if ({a_out1, a_vld1, done1, busy1, in_ready1} !== {8'h80, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL rows1_beat got out=%h vld=%b done=%b busy=%b rdy=%b expected 80/1/1/0/1",
               a_out1, a_vld1, done1, busy1, in_ready1);
    end
    @(negedge clk);
    tests++;
    if ({a_out1, a_vld1, done1} !== {8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL rows1_after got out=%h vld=%b done=%b expected 00/0/0", a_out1, a_vld1, done1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gapped();
    test_next_tile();
    test_reset_flush();
    test_rows1();
    repeat (6) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
